// File: rtl/router_pkg.sv
// Shared constants for the router FIFO: default geometry, header-marker
// position and the packet-length field carried in a header byte.
package router_pkg;

    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_WIDTH = 8;

    // Marker sits just above the payload byte in a stored word.
    localparam int unsigned HDR_BIT   = DEF_WIDTH;

    // Header byte bits [7:2] carry the payload length.
    localparam int unsigned LEN_MSB   = 7;
    localparam int unsigned LEN_LSB   = 2;
    localparam int unsigned CNT_W     = LEN_MSB - LEN_LSB + 1;

    // Bytes still to drain after a header: payload length plus parity byte.
    function automatic logic [CNT_W-1:0] pkt_len(input logic [LEN_MSB:LEN_LSB] len_field);
        return CNT_W'(len_field) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Read/write pointers and full/empty flags for the router FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module router_fifo_ptr
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
)
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     wr_go_c,
    output logic                     rd_go_c,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Flags straight from the pointers; accepted operations are gated by them.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign wr_go_c = write_enb && !full;
    assign rd_go_c = read_enb && !empty;
    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    // Pointer update; flush wins over any concurrent access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_go_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/router_fifo.sv
// Router output FIFO: stores {header marker, byte}, tracks how many bytes of
// the current packet remain, and zeroes data_out once a packet has drained.
// Optional feature: define ROUTER_FIFO_OVF_ERR_EN to add the sticky ovf_err
// output flagging writes while full or reads while empty.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef ROUTER_FIFO_OVF_ERR_EN
    ,
    output logic             ovf_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH:0]     mem [DEPTH];
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic               wr_go_c;
    logic               rd_go_c;
    logic [WIDTH:0]     rd_word_c;
    logic [CNT_W-1:0]   pkt_cnt;

    router_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .wr_go_c    (wr_go_c),
        .rd_go_c    (rd_go_c),
        .full       (full),
        .empty      (empty)
    );

    assign rd_word_c = mem[rd_addr];

    // Storage is never reset; pointers guarantee no unwritten entry is read.
    always_ff @(posedge clock) begin
        if (wr_go_c && !soft_reset) begin
            mem[wr_addr] <= {lfd_state, data_in};
        end
    end

    // Read data and packet byte counter; idle with nothing left to drain clears data_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            pkt_cnt  <= '0;
        end else if (soft_reset) begin
            data_out <= '0;
            pkt_cnt  <= '0;
        end else if (rd_go_c) begin
            data_out <= rd_word_c[WIDTH-1:0];
            if (rd_word_c[WIDTH]) begin
                pkt_cnt <= pkt_len(rd_word_c[LEN_MSB:LEN_LSB]);
            end else if (pkt_cnt != '0) begin
                pkt_cnt <= pkt_cnt - CNT_W'(1);
            end
        end else if (pkt_cnt == '0) begin
            data_out <= '0;
        end
    end

`ifdef ROUTER_FIFO_OVF_ERR_EN
    // Sticky flag for any access the flags refused.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if (soft_reset) begin
            ovf_err <= 1'b0;
        end else if ((write_enb && full) || (read_enb && empty)) begin
            ovf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: the driver queues the expected
// data_out/full/empty for the cycle after each stimulus step, and a
// monitor on the falling edge pops and compares them.
module tb_router_fifo;

    logic       clock;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef ROUTER_FIFO_OVF_ERR_EN
    logic       ovf_err;
`endif

    router_fifo #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
`ifdef ROUTER_FIFO_OVF_ERR_EN
        ,
        .ovf_err    (ovf_err)
`endif
    );

    typedef struct packed {
        int         cyc;
        int         tid;
        int         idx;
        logic [7:0] dout;
        logic       full;
        logic       empty;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   cur_tid;
    int   cur_idx;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show after the edge.
    task automatic step(input logic we, input logic re, input logic lfd, input logic sr,
                        input logic [7:0] din, input logic [7:0] e_dout,
                        input logic e_full, input logic e_empty);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        soft_reset = sr;
        data_in    = din;
        exp_q.push_back('{cyc + 1, cur_tid, cur_idx, e_dout, e_full, e_empty});
        cur_idx = cur_idx + 1;
        @(posedge clock);
        #1;
    endtask

    task automatic new_test(input int tid);
        cur_tid = tid;
        cur_idx = 0;
    endtask

    // Monitor: compare every expectation whose cycle has been reached.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check($sformatf("t%0d.%0d data_out", mon_e.tid, mon_e.idx), 32'(data_out), 32'(mon_e.dout));
            check($sformatf("t%0d.%0d full", mon_e.tid, mon_e.idx), 32'(full), 32'(mon_e.full));
            check($sformatf("t%0d.%0d empty", mon_e.tid, mon_e.idx), 32'(empty), 32'(mon_e.empty));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    logic [7:0] pkt [5];

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0; cur_tid = 0; cur_idx = 0;
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5F;

        // Reset values
        #3;
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset full", 32'(full), 32'h0);
        check("reset empty", 32'(empty), 32'h1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Header 0x0D (length 3): header, 3 payload, parity, then drained to 0
        new_test(30);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i == 0, 1'b0, pkt[i], 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pkt[i], 1'b0, i == 4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Fill to 16, overflow write ignored, drain in order
        new_test(31);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i), 8'h00, i == 15, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'(8'h30 + i), 1'b0, i == 15);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // 8 stored, 20 cycles of simultaneous write+read (pointers wrap), then drain
        new_test(32);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i), 8'h00, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + j),
                 (j < 8) ? 8'(8'h50 + j) : 8'(8'h60 + j - 8), 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'(8'h6C + k), 1'b0, k == 7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Soft reset beats a concurrent write and read
        new_test(33);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i), 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Async reset after 3 of 5 reads
        new_test(34);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i == 0, 1'b0, pkt[i], 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pkt[i], 1'b0, 1'b0);
        read_enb = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("t34 async data_out", 32'(data_out), 32'h0);
        check("t34 async empty", 32'(empty), 32'h1);
        check("t34 async full", 32'(full), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h42, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

`ifdef ROUTER_FIFO_OVF_ERR_EN
        // Read on empty sets the sticky error; only soft_reset clears it
        new_test(35);
        check("t35 ovf idle", 32'(ovf_err), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t35 ovf set", 32'(ovf_err), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t35 ovf held", 32'(ovf_err), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t35 ovf cleared", 32'(ovf_err), 32'h0);
`endif

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of storage entries (power of two, >=4).
REQ-002 SHALL have parameter WIDTH, default 8, meaning payload byte width; stored word is WIDTH+1 bits (MSB = header marker).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 soft_reset  input  1  synchronous flush from the router FSM timeout logic.
REQ-006 write_enb  input  1  write request.
REQ-007 read_enb  input  1  read request from the output port.
REQ-008 lfd_state  input  1  high when the byte being written is the header.
REQ-009 data_in  input  WIDTH  byte from the router register stage (its dout).
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  high when DEPTH words are stored.
REQ-012 empty  output  1  high when zero words are stored.

Function
REQ-013 SHALL use read/write pointers of log2(DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = pointers equal; both combinational from pointers.
REQ-014 SHALL write {lfd_state, data_in} at wr_ptr and increment wr_ptr when write_enb && !full.
REQ-015 SHALL read the entry at rd_ptr into data_out and increment rd_ptr when read_enb && !empty; read latency is one clock.
REQ-016 Simultaneous write and read SHALL both occur when neither flag blocks them; when full, only the read occurs; when empty, only the write occurs.
REQ-017 Pointers SHALL wrap modulo 2*DEPTH; storage index is pointer low bits.
REQ-018 SHALL keep a 6-bit packet counter: on a read whose marker bit is 1, counter loads data[7:2]+1 (payload length plus parity byte).
REQ-019 On a read whose marker bit is 0 and counter != 0, counter SHALL decrement by 1.
REQ-020 When counter == 0 and no header read occurs, data_out SHALL be driven to 0 on the next edge (packet fully drained).
REQ-021 Writes with full asserted and reads with empty asserted SHALL be ignored without corrupting storage or pointers.
REQ-022 soft_reset SHALL, on the next edge, zero both pointers, the counter and data_out, taking priority over any concurrent read or write.

Reset
REQ-023 reset SHALL asynchronously clear pointers, counter and data_out to 0; outputs: data_out=0, full=0, empty=1.
REQ-024 Storage array contents SHALL NOT require reset; no read of an unwritten entry is possible after reset.
REQ-025 Reset asserted mid-packet SHALL abandon the packet; first write after release lands at index 0.

Configuration
REQ-026 Macro ROUTER_FIFO_OVF_ERR_EN, when defined, SHALL add output ovf_err (1 bit): sticky high after any write_enb with full or read_enb with empty; cleared by reset or soft_reset.
REQ-027 Without ROUTER_FIFO_OVF_ERR_EN the port and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-028 Shared package router_pkg SHALL hold DEPTH/WIDTH defaults, the header-marker bit index, and the length field slice constants (bits 7:2).
REQ-029 The read/write pointer and flag logic SHALL be a sub-module router_fifo_ptr; storage, counter and data_out stay in router_fifo.

Verification
REQ-030 Reset then write header 0x0D (lfd=1), payload 0xA1,0xA2,0xA3, parity 0x5F; read 5 times -> data_out 0x0D,0xA1,0xA2,0xA3,0x5F on successive cycles, then 0x00, empty=1.
REQ-031 Write 16 bytes without reads -> full=1 after 16th; 17th write ignored; read 16 -> original order, empty=1.
REQ-032 With 8 stored, assert write_enb and read_enb together for 20 cycles -> occupancy stays 8, pointers wrap past 31 to 0, data order preserved.
REQ-033 Store 6 bytes, pulse soft_reset concurrently with a write -> next cycle empty=1, data_out=0, write discarded.
REQ-034 Assert reset mid-packet (after 3 of 5 reads) -> data_out=0, empty=1 immediately without clock edge.
REQ-035 With ROUTER_FIFO_OVF_ERR_EN: read_enb on empty -> ovf_err=1 next edge, held until soft_reset; without the macro the port does not exist.
